// File: rtl/seq_detect_param.sv
// Serial N-bit pattern detector with a registered match pulse, a saturating match counter and overlap control.
// Optional SEQ_DETECT_MASK_EN adds a per-bit don't-care mask to the compare.
module seq_detect_param #(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inp,
    input  logic                     in_valid,
    input  logic [N-1:0]             pattern,
    input  logic                     overlap,
    input  logic                     clear,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [N-1:0]             mask,
`endif
    output logic                     out,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(N+1)-1:0]   fill
);

    localparam int FW = $clog2(N+1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(N);
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      hist_q, hist_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q, out_d;

    logic [N-1:0]      window;
    logic [N-1:0]      diff;
    logic              accept;
    logic              window_full;
    logic              match;

    assign accept = in_valid & ~clear;
    assign window = (hist_q << 1) | N'(inp);

`ifdef SEQ_DETECT_MASK_EN
    assign diff = (window ^ pattern) & ~mask;
`else
    assign diff = window ^ pattern;
`endif

    // The window is complete if this accepted bit is the N-th one since the last restart.
    assign window_full = (state_q == ARMED) ||
                         ((state_q == FILLING) && (fill_q == FILL_LAST)) ||
                         ((state_q == EMPTY) && (FILL_LAST == '0));
    assign match       = accept && window_full && (diff == '0);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        if (clear) begin
            state_d = EMPTY;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            hist_d = window;
            out_d  = match;
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (match && !overlap) begin
                state_d = EMPTY;
                fill_d  = '0;
            end else if (state_q != ARMED) begin
                fill_d  = fill_q + FW'(1);
                state_d = (fill_d == FILL_MAX) ? ARMED : FILLING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign fill      = fill_q;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector. It watches a qualified 1-bit input stream for a run-time programmable N-bit pattern. It produces a registered one-cycle match pulse and a saturating match counter, and supports overlapping or non-overlapping detection. It sits in the control/monitor path, replacing fixed-pattern hand-coded FSM detectors.

Parameters:
- N, 3, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- inp  input  1  serial data bit.
- in_valid  input  1  inp is accepted on an edge only when this is high.
- pattern  input  N  target pattern; pattern[N-1] is the first bit received, pattern[0] the last.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clear  input  1  synchronous clear of history, counter and out.
- out  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- fill  output  $clog2(N+1)  number of valid history bits, 0..N.

Behaviour:
- Reset (rst=1, async): history=0, fill=0, out=0, match_cnt=0, state EMPTY. Outputs go low without a clock edge.
- History register hist[N-1:0]. On an accepted bit: hist <= {hist[N-2:0], inp}. The newest bit is at the LSB.
- State machine (encoded by fill):
  - EMPTY: fill=0.
  - FILLING: 0<fill<N.
  - ARMED: fill=N.
  - Each accepted bit increments fill, saturating at N.
- Match condition, evaluated combinationally on an accepted bit:
  - {hist[N-2:0], inp} == pattern, AND
  - fill >= N-1 (the window is complete including the new bit).
- out <= (in_valid && match). out is high for exactly one cycle after the accepting edge (1-cycle latency). There is no match and no pulse on cycles where in_valid=0; out is 0 on those cycles.
- On a match: match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 (no wrap).
- Overlap=1: fill stays N after a match, so the trailing bits can start the next match.
- Overlap=0: on a match, fill <= 0 (state EMPTY). The next match needs N fresh bits. hist contents are don't-care while fill<N.
- pattern and overlap are sampled on each accepted bit. A change takes effect at the next accepted bit; no flush occurs.
- clear=1 (sync): fill<=0, match_cnt<=0, out<=0. clear has priority over in_valid in the same cycle; that bit is dropped and no match is counted.
- inp toggling while in_valid=0 has no effect on any state.
- rst asserted mid-stream aborts everything immediately. The first bit accepted after release is counted as bit 1.

Optional Feature:
- Macro: SEQ_DETECT_MASK_EN.
- Defined: adds input port `mask` (N bits). Bit positions with mask[i]=1 are don't-care in the compare; the match condition becomes ((window ^ pattern) & ~mask) == 0. All-ones mask with fill requirement met matches every accepted bit once ARMED.
- Undefined: the port is absent and the compare is exact equality. All other behaviour is identical.

Test Plan:
1. N=3, pattern=3'b001, overlap=1. Stream 0,0,1 with in_valid=1 every cycle -> out=1 for one cycle after the third accepting edge; match_cnt=1; fill=3.
2. N=4, pattern=4'b1010. Stream 1,0,1,0,1,0 with overlap=1 -> pulses after bits 4 and 6, match_cnt=2. Same stream with overlap=0 -> single pulse after bit 4, match_cnt=1, fill=2 at end.
3. N=3, pattern=001. Bits 0,0,1 with in_valid=0 gaps of 2 cycles between them, inp toggling during the gaps -> exactly one pulse after the third valid bit; fill never counts gap cycles.
4. CNT_W=2, pattern=3'b111, overlap=1. Seven 1s -> five matches; match_cnt=3 (saturated), out pulses five times.
5. Drive 0,0 then clear=1 together with in_valid=1, inp=1 -> no pulse, fill=0, match_cnt=0. Then 0,0,1 -> match. Async rst mid-stream (fill=2) -> out, fill, match_cnt = 0 before the next edge.
6. SEQ_DETECT_MASK_EN defined, pattern=3'b001, mask=3'b010. Stream 0,1,1 -> match; stream 1,0,1 -> no match.
